// File: rtl/reg_file_mp.sv
// Multi-port architectural register file with same-cycle write-to-read forwarding
// and a per-register busy scoreboard driven by issue, writeback and flush.
module reg_file_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NREG     = 32,
  parameter int NRD      = 4,
  parameter int NWR      = 2,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                  rf_in_clk,
  input  logic                  rf_in_rstL,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic [NWR-1:0]        wr_en,
  input  logic [NWR*ADDR_W-1:0] wr_addr,
  input  logic [NWR*DATA_W-1:0] wr_data,
  input  logic                  iss_en,
  input  logic [ADDR_W-1:0]     iss_addr,
  input  logic                  flush,
  output logic [NREG-1:0]       busy_vec
);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [NREG-1:0]   busy_q, busy_d;
  logic [NREG-1:0]   wr_hit;

  logic [ADDR_W-1:0] wa [NWR];
  logic [DATA_W-1:0] wd [NWR];
  logic [ADDR_W-1:0] ra [NRD];

  // An address names real, writable storage: in range and not the hard-wired zero.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (32'(a) < 32'(NREG)) && !(ZERO_REG && (a == '0));
  endfunction

  always_comb begin
    for (int j = 0; j < NWR; j++) begin
      wa[j] = wr_addr[j*ADDR_W +: ADDR_W];
      wd[j] = wr_data[j*DATA_W +: DATA_W];
    end
    for (int k = 0; k < NRD; k++) begin
      ra[k] = rd_addr[k*ADDR_W +: ADDR_W];
    end
  end

  // Ascending port loop makes the highest-indexed matching port the winner.
  always_comb begin
    // NOTE: every variable gets a default before any conditional update so no latch is inferred.
    regs_d = regs_q;
    wr_hit = '0;
    for (int i = 0; i < NREG; i++) begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && addr_ok(wa[j]) && (32'(wa[j]) == 32'(i))) begin
          regs_d[i] = wd[j];
          wr_hit[i] = 1'b1;
        end
      end
    end
  end

  // Flush beats issue, issue beats writeback: a newly issued producer supersedes the old one.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NREG; i++) begin
      if (flush) begin
        busy_d[i] = 1'b0;
      end else if (iss_en && addr_ok(iss_addr) && (32'(iss_addr) == 32'(i))) begin
        busy_d[i] = 1'b1;
      end else if (wr_hit[i]) begin
        busy_d[i] = 1'b0;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int k = 0; k < NRD; k++) begin
      if (rf_in_rstL && addr_ok(ra[k])) begin
        for (int i = 0; i < NREG; i++) begin
          if (32'(ra[k]) == 32'(i)) begin
            rd_data[k*DATA_W +: DATA_W] = regs_q[i];
            rd_busy[k]                  = busy_q[i];
          end
        end
        // An in-flight writeback forwards its data and retires the busy status early.
        for (int j = 0; j < NWR; j++) begin
          if (wr_en[j] && (wa[j] == ra[k])) begin
            rd_data[k*DATA_W +: DATA_W] = wd[j];
            rd_busy[k]                  = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge rf_in_clk or negedge rf_in_rstL) begin
    if (!rf_in_rstL) begin
      // NOTE: the register array is reset because software may read registers before writing them.
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-port general-purpose register file with write-to-read forwarding and a per-register busy scoreboard. It serves as the next-generation architectural register file for the multi-issue core: NRD combinational read ports feed decode/issue, NWR write ports take writeback, and the issue stage marks destination registers busy until their writeback lands.

## Interface
- DATA_W, 32, register data width
- ADDR_W, 5, register address width
- NREG, 32, number of registers (≤ 2^ADDR_W)
- NRD, 4, number of read ports
- NWR, 2, number of write ports
- ZERO_REG, 1, 1 = register 0 hard-wired to zero, never written, never busy

Ports:
- rf_in_clk  in  1  single clock; all state updates on rising edge
- rf_in_rstL  in  1  reset, asynchronous, active-low
- rd_addr  in  NRD*ADDR_W  read addresses, port k at [k*ADDR_W +: ADDR_W]
- rd_data  out  NRD*DATA_W  read data, port k at [k*DATA_W +: DATA_W]
- rd_busy  out  NRD  busy status of each read register after forwarding
- wr_en  in  NWR  write enables
- wr_addr  in  NWR*ADDR_W  write addresses
- wr_data  in  NWR*DATA_W  write data
- iss_en  in  1  mark iss_addr busy (new producer issued)
- iss_addr  in  ADDR_W  destination register being issued
- flush  in  1  clear every busy bit (pipeline flush)
- busy_vec  out  NREG  registered busy bits, bit i = register i

## Operation
- Storage: NREG × DATA_W flops; scoreboard: NREG busy flops.
- Reset (rf_in_rstL low, asynchronous): all registers 0, all busy bits 0. While reset is low, rd_data = 0 and rd_busy = 0 on all ports. busy_vec = 0.
- Write: at the rising edge, for each port j with wr_en[j]=1, addr < NREG, and not (ZERO_REG and addr = 0): Regs[addr] ← wr_data[j]. Several ports on the same address: the highest-indexed port wins. Addresses ≥ NREG are ignored.
- Read port k, combinational, priority order:
  1. reset active → 0.
  2. ZERO_REG and rd_addr = 0 → 0, rd_busy = 0.
  3. rd_addr ≥ NREG → 0, rd_busy = 0.
  4. Any enabled write port targets rd_addr → forward the data of the highest-indexed matching port; rd_busy = 0.
  5. Otherwise → Regs[rd_addr], rd_busy = busy[rd_addr].
- Scoreboard update at each rising edge, per register i:
  - flush=1 → busy[i] ← 0; this overrides everything.
  - else if iss_en and iss_addr = i (and i valid, not zero-reg) → busy[i] ← 1. An issue beats a same-cycle write to the same register, because the new producer supersedes it.
  - else if any enabled write port targets i → busy[i] ← 0.
  - else hold.
- A flush does not cancel same-cycle writes. Register contents are still updated.

## Timing
- Read latency 0: rd_data and rd_busy are combinational from rd_addr, wr_*, and the state.
- Write latency 1: data is visible from storage on the cycle after the edge, and through forwarding on the same cycle.
- iss_en at edge N → busy_vec bit set after edge N; rd_busy reports it from cycle N+1.
- Writeback at edge N clears busy after edge N. On cycle N itself, forwarding already reports rd_busy = 0.
- Reset deassertion has no internal synchronisation. Inputs must be quiet (wr_en = 0, iss_en = 0) during the first edge after release.

## Test plan
- Reset mid-operation: write R5=0xDEADBEEF, mark R5 busy, then pulse rf_in_rstL low between edges → rd_data and busy_vec go to 0 immediately without waiting for a clock edge; after release, reading R5 returns 0 and not busy.
- Forwarding priority: wr_en=2'b11, both ports to R7, data 0x11/0x22, read R7 on all 4 ports in the same cycle → all return 0x22 with rd_busy=0; next cycle storage returns 0x22.
- Zero register: write 0xFFFFFFFF to R0 and issue R0 → reads of R0 return 0, busy_vec[0]=0 (ZERO_REG=1). Rerun with ZERO_REG=0 → R0 reads 0xFFFFFFFF.
- Scoreboard: issue R3 at edge 1 → busy_vec[3]=1 from cycle 2; write R3=0x55 at edge 4 → rd_busy[3]=0 on cycle 4 with data 0x55, and busy_vec[3]=0 after the edge.
- Issue/write/flush collision: same cycle iss_en to R9 and write R9=0xA → busy_vec[9]=1, R9=0xA. Repeat with flush=1 → busy_vec[9]=0, R9=0xA.
- Parameter sweep: NRD=2, NWR=3, NREG=16, ADDR_W=5, address 20 read/written → read returns 0, storage is untouched, and random reads/writes compare against a reference model.
